// File: rtl/spec_exec_pkg.sv
// spec_exec_pkg: shared widths, opcodes, key default and FSM encoding for the specialised exec unit
package spec_exec_pkg;
    localparam int DEF_DATA_W = 19;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_LEN_W  = 8;
    localparam logic [3:0] OP_INC = 4'b1100;
    localparam logic [3:0] OP_ENC = 4'b1101;
    localparam logic [3:0] OP_DEC = 4'b1110;
    localparam logic [DEF_DATA_W-1:0] KEY_DEFAULT = 19'h55555;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;
    function automatic logic op_legal(input logic [3:0] op);
        return op == OP_INC || op == OP_ENC || op == OP_DEC;
    endfunction
endpackage

// File: rtl/spec_exec_mem.sv
// spec_exec_mem: single-port synchronous RAM with registered read (read-before-write)
module spec_exec_mem #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[addr];
    end
endmodule

// File: rtl/specialized_exec_unit.sv
// specialized_exec_unit: block INC/ENC/DEC engine over an internal word memory,
// with start/busy/done handshake, loadable key and a host load/read port usable in IDLE.
module specialized_exec_unit #(
    parameter int DATA_W = spec_exec_pkg::DEF_DATA_W,
    parameter int ADDR_W = spec_exec_pkg::DEF_ADDR_W,
    parameter int LEN_W  = spec_exec_pkg::DEF_LEN_W,
    parameter logic [DATA_W-1:0] KEY_DEFAULT = DATA_W'(spec_exec_pkg::KEY_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op_code,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              key_we,
    input  logic [DATA_W-1:0] key_in,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);
    import spec_exec_pkg::*;

    function automatic logic [DATA_W-1:0] apply_op(input logic [3:0] op, input logic [DATA_W-1:0] d,
                                                   input logic [DATA_W-1:0] k);
        return op == OP_INC ? d + DATA_W'(1) : d ^ k;
    endfunction

    state_t            state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, cnt, cnt_nxt;
    logic [DATA_W-1:0] key, run_key, host_hold, mem_rdata, mem_wdata, exec_word;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, host_vld, idle;

    // Host owns the memory port only in IDLE; the engine owns it for the whole run.
    always_comb begin
        idle      = state == S_IDLE;
        cnt_nxt   = cnt + LEN_W'(1);
        exec_word = apply_op(op_q, mem_rdata, run_key);
        mem_we    = idle ? host_we : state == S_EXEC;
        mem_addr  = idle ? host_addr : (state == S_EXEC ? dst_q : src_q) + ADDR_W'(cnt);
        mem_wdata = idle ? host_wdata : exec_word;
    end

    // Host read data is only fresh after an IDLE cycle; otherwise the last value is held.
    assign host_rdata = host_vld ? mem_rdata : host_hold;

    spec_exec_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            key       <= KEY_DEFAULT;
            run_key   <= KEY_DEFAULT;
            op_q      <= OP_INC;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cnt       <= '0;
            host_vld  <= 1'b0;
            host_hold <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            host_vld  <= idle;
            host_hold <= host_rdata;
            case (state)
                S_IDLE: begin
                    if (key_we) key <= key_in;
                    if (start && (!op_legal(op_code) || len == '0)) err <= 1'b1;
                    else if (start) begin
                        op_q    <= op_code;
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= len;
                        run_key <= key;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_READ;
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    result <= exec_word;
                    cnt    <= cnt_nxt;
                    if (cnt_nxt == len_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else state <= S_READ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_specialized_exec_unit.sv
// tb_specialized_exec_unit: directed vector table plus hand-written run sequences
module tb_specialized_exec_unit;
    import spec_exec_pkg::*;

    logic        clk = 0, rst_n = 0, start = 0, key_we = 0, host_we = 0;
    logic [3:0]  op_code = 0;
    logic [9:0]  src_addr = 0, dst_addr = 0, host_addr = 0;
    logic [7:0]  len = 0;
    logic [18:0] key_in = 0, host_wdata = 0;
    logic [18:0] host_rdata, result;
    logic        busy, done, err;

    int checks = 0, errors = 0;

    specialized_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .key_we(key_we), .key_in(key_in), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata), .busy(busy),
        .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [18:0] din;
        logic [18:0] key;
        logic [18:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input logic [9:0] a, input logic [18:0] d);
        host_we = 1; host_addr = a; host_wdata = d;
        cyc();
        host_we = 0;
    endtask

    task automatic hread(input logic [9:0] a, output logic [18:0] d);
        host_addr = a;
        cyc();
        d = host_rdata;
    endtask

    task automatic set_key(input logic [18:0] k);
        key_we = 1; key_in = k;
        cyc();
        key_we = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [9:0] s, input logic [9:0] d, input logic [7:0] l);
        op_code = op; src_addr = s; dst_addr = d; len = l; start = 1;
        cyc();
        start = 0;
    endtask

    // Legal run: busy right after the start edge, done after exactly 2*len edges, back to IDLE.
    task automatic run(input string name, input logic [3:0] op, input logic [9:0] s, input logic [9:0] d,
                       input logic [7:0] l);
        int n = 0;
        issue(op, s, d, l);
        chk({name, " busy"}, busy, 1);
        do begin
            cyc();
            n++;
        end while (!done && n < 2 * int'(l) + 10);
        chk({name, " done edge"}, n, 2 * int'(l));
        cyc();
        chk({name, " idle"}, {busy, done}, 0);
    endtask

    logic [18:0] w, w0, w1, w2;
    logic [9:0]  sum_addr[9] = '{10'h100, 10'h101, 10'h102, 10'h008, 10'h020, 10'h021, 10'h022, 10'h023, 10'h051};
    logic [18:0] orig[4] = '{19'h00001, 19'h7FFFF, 19'h2AAAA, 19'h12345};
    int          sum_before, sum_after, seen;

    initial begin
        vecs[0] = '{OP_INC, 19'h00000, 19'h55555, 19'h00001};
        vecs[1] = '{OP_INC, 19'h7FFFF, 19'h55555, 19'h00000};
        vecs[2] = '{OP_ENC, 19'h00000, 19'h55555, 19'h55555};
        vecs[3] = '{OP_ENC, 19'h00010, 19'h55555, 19'h55545};
        vecs[4] = '{OP_DEC, 19'h55545, 19'h55555, 19'h00010};
        vecs[5] = '{OP_ENC, 19'h7FFFF, 19'h12345, 19'h6DCBA};
        vecs[6] = '{OP_DEC, 19'h12345, 19'h12345, 19'h00000};

        // 1: reset values, then ENC of a zero word gives the default key
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        chk("rst outputs", {busy, done, err}, 0);
        chk("rst result", result, 0);
        chk("rst host_rdata", host_rdata, 0);
        hwrite(10'h000, 19'h00000);
        run("t1", OP_ENC, 10'h000, 10'h010, 1);
        chk("t1 result", result, 19'h55555);

        // 2: single-word ENC to another address
        hwrite(10'h004, 19'h00010);
        run("t2", OP_ENC, 10'h004, 10'h008, 1);
        hread(10'h008, w);
        chk("t2 mem8", w, 19'h55545);

        // 3: INC across the source address wrap
        hwrite(10'h3FE, 19'h7FFFF);
        hwrite(10'h3FF, 19'h00005);
        hwrite(10'h000, 19'h00009);
        run("t3", OP_INC, 10'h3FE, 10'h100, 3);
        chk("t3 result", result, 19'h0000A);
        hread(10'h100, w0); hread(10'h101, w1); hread(10'h102, w2);
        chk("t3 w0", w0, 19'h00000);
        chk("t3 w1", w1, 19'h00006);
        chk("t3 w2", w2, 19'h0000A);

        // vector table: single-word ops with assorted data and keys
        foreach (vecs[i]) begin
            set_key(vecs[i].key);
            hwrite(10'h050, vecs[i].din);
            run($sformatf("vec%0d", i), vecs[i].op, 10'h050, 10'h051, 1);
            chk($sformatf("vec%0d result", i), result, vecs[i].exp);
            hread(10'h051, w);
            chk($sformatf("vec%0d mem", i), w, vecs[i].exp);
        end

        // 4: ENC then DEC in place restores the words
        set_key(19'h12345);
        foreach (orig[i]) hwrite(10'h020 + 10'(i), orig[i]);
        run("t4 enc", OP_ENC, 10'h020, 10'h020, 4);
        foreach (orig[i]) begin
            hread(10'h020 + 10'(i), w);
            chk($sformatf("t4 enc w%0d", i), w, orig[i] ^ 19'h12345);
        end
        run("t4 dec", OP_DEC, 10'h020, 10'h020, 4);
        foreach (orig[i]) begin
            hread(10'h020 + 10'(i), w);
            chk($sformatf("t4 dec w%0d", i), w, orig[i]);
        end

        // start with key_we: run uses old key; start with host_we: write lands first
        hwrite(10'h060, 19'h00F0F);
        key_we = 1; key_in = 19'h00001;
        run("t4 keyold", OP_ENC, 10'h060, 10'h061, 1);
        key_we = 0;
        chk("t4 keyold result", result, 19'h00F0F ^ 19'h12345);
        run("t4 keynew", OP_ENC, 10'h060, 10'h061, 1);
        chk("t4 keynew result", result, 19'h00F0E);
        host_we = 1; host_addr = 10'h030; host_wdata = 19'h00777;
        run("t4 hostwr", OP_INC, 10'h030, 10'h031, 1);
        host_we = 0;
        chk("t4 hostwr result", result, 19'h00778);

        // 5: illegal op and len==0 are rejected without touching memory
        sum_before = 0;
        foreach (sum_addr[i]) begin hread(sum_addr[i], w); sum_before += int'(w); end
        for (int k = 0; k < 2; k++) begin
            issue(k == 0 ? 4'b0000 : OP_INC, 10'h100, 10'h101, k == 0 ? 8'd1 : 8'd0);
            chk($sformatf("t5 err%0d", k), {err, busy, done}, 3'b100);
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                cyc();
                seen += int'(err) + int'(busy) + int'(done);
            end
            chk($sformatf("t5 quiet%0d", k), seen, 0);
        end
        sum_after = 0;
        foreach (sum_addr[i]) begin hread(sum_addr[i], w); sum_after += int'(w); end
        chk("t5 checksum", sum_after, sum_before);

        // 6: reset just before edge 3 of a len8 INC leaves only word 0 updated
        for (int i = 0; i < 8; i++) hwrite(10'h200 + 10'(i), 19'h00100 + 19'(16 * i));
        issue(OP_INC, 10'h200, 10'h200, 8);
        cyc();
        cyc();
        #2 rst_n = 0;
        #1;
        chk("t6 rst outputs", {busy, done, err}, 0);
        chk("t6 rst result", result, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        hread(10'h200, w0); hread(10'h201, w1); hread(10'h207, w2);
        chk("t6 w0", w0, 19'h00101);
        chk("t6 w1", w1, 19'h00110);
        chk("t6 w7", w2, 19'h00170);
        run("t6 rerun", OP_INC, 10'h200, 10'h210, 2);
        hread(10'h210, w0); hread(10'h211, w1);
        chk("t6 rerun w0", w0, 19'h00102);
        chk("t6 rerun w1", w1, 19'h00111);
        run("t6 key", OP_ENC, 10'h000, 10'h012, 1);
        chk("t6 default key", result, 19'h00009 ^ 19'h55555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
